// File: rtl/cpu_pkg.sv
// Shared core types and constants for the fetch and decode stages.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_bundle_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry output buffer between instruction memory returns and the decoder.
// The head entry is a dedicated register so the consumer never sees a
// combinational path from the push data.
module fetch_skid_fifo
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  fetch_bundle_t         i_push_data,
  input  logic                  i_pop,
  output fetch_bundle_t         o_head,
  output logic [FIFO_CNT_W-1:0] o_count
);

  fetch_bundle_t         r_head;
  fetch_bundle_t         r_tail;
  logic [FIFO_CNT_W-1:0] r_count;

  fetch_bundle_t         w_head_d;
  fetch_bundle_t         w_tail_d;
  logic [FIFO_CNT_W-1:0] w_count_d;
  logic                  w_pop;

  assign w_pop = i_pop & (r_count != '0);

  // Next entry contents and occupancy; flush only clears the count.
  always_comb begin
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_count_d = r_count;
    case ({i_push, w_pop})
      2'b10: begin
        if (r_count == '0) w_head_d = i_push_data;
        else               w_tail_d = i_push_data;
        w_count_d = r_count + FIFO_CNT_W'(1);
      end
      2'b01: begin
        w_head_d  = r_tail;
        w_count_d = r_count - FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (r_count == FIFO_CNT_W'(1)) begin
          w_head_d = i_push_data;
        end else begin
          w_head_d = r_tail;
          w_tail_d = i_push_data;
        end
      end
      default: ;
    endcase
    if (i_flush) w_count_d = '0;
  end

  // Entry and count registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads to a one-cycle
// synchronous instruction memory and hands {instr, pc} to the decoder over a
// valid/ready handshake. A redirect squashes everything in flight.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_W-1:0]     instr,
  output logic [PC_W-1:0]        instr_pc
);

  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  logic [PC_W-1:0]       r_fetch_pc;
  logic                  r_inflight;
  logic [PC_W-1:0]       r_inflight_pc;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_push;
  logic [OCC_W-1:0]      w_occupancy;
  logic [FIFO_CNT_W-1:0] w_count;
  fetch_bundle_t         w_head;
  fetch_bundle_t         w_push_data;

  assign w_pop = instr_valid & instr_ready;

  // Entries that will still be held or owed after this cycle's pop; issue
  // only while that leaves room for the read we are about to start.
  assign w_occupancy = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue     = ~rst & ~redirect_valid & (w_occupancy < OCC_W'(FIFO_DEPTH));

  // A read returns in the cycle right after its issue, so a redirect that
  // lands while it is outstanding squashes it by refusing that same return.
  assign w_push            = r_inflight & ~redirect_valid & ~rst;
  assign w_push_data.instr = imem_rdata;
  assign w_push_data.pc    = r_inflight_pc;

  // Fetch PC and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      if (redirect_valid)  r_fetch_pc <= align_pc(redirect_pc);
      else if (w_issue)    r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk         (clk),
    .i_rst       (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Memory strobe and address; the address is forced to zero during reset.
  assign imem_en   = w_issue;
  assign imem_addr = rst ? '0 : r_fetch_pc[IMEM_ADDR_W+1:2];

  // Decoder-facing outputs come from the buffer head and read as zero in reset.
  assign instr_valid = ~rst & (w_count != '0);
  assign instr       = rst ? '0 : w_head.instr;
  assign instr_pc    = rst ? '0 : w_head.pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the single-issue MIPS-style core; it sits directly upstream of `instruction_decoder`. It owns the program counter, issues word reads to a synchronous instruction memory with one-cycle read latency, and presents each returned 32-bit instruction with its PC on a valid/ready handshake. A redirect input (branch or jump target) squashes in-flight and buffered fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `IMEM_ADDR_W`, default 10: word-address width of instruction memory (1024 words).

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  load a new fetch PC this cycle.
- `redirect_pc`  in  32  target byte address; bits [1:0] ignored (treated as 0).
- `imem_en`  out  1  read strobe to instruction memory.
- `imem_addr`  out  IMEM_ADDR_W  word address, equal to `pc[IMEM_ADDR_W+1:2]`.
- `imem_rdata`  in  32  read data, valid the cycle after `imem_en`.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction.
- `instr_ready`  in  1  decoder accepts; transfer occurs when `instr_valid & instr_ready`.
- `instr`  out  32  instruction word, fed to `instruction_decoder.instruction`.
- `instr_pc`  out  32  byte address of `instr`.

## Operation
- Registers:
  - `fetch_pc`: next address to issue.
  - `inflight`: one read outstanding, with its PC.
  - Output buffer: 2-entry FIFO of {instr, pc}, count 0..2.
- Issue rule:
  - `imem_en = !rst & !redirect_valid & (count + inflight - pop < 2)`, where `pop = instr_valid & instr_ready`.
  - On issue, `fetch_pc <= fetch_pc + 4`, mod 2^32.
  - `imem_addr` wraps naturally through memory.
- Return: the cycle after an issue, `imem_rdata` is pushed into the FIFO with the issued PC and `inflight` clears. Pushing into a full FIFO cannot occur by construction; the bench asserts this.
- Output: `instr_valid = count != 0`. `instr`/`instr_pc` are the FIFO head, registered with no combinational path from `imem_rdata`. They are held stable while `instr_valid & !instr_ready`.
- Redirect:
  - Cycle R: FIFO cleared; an in-flight read is marked squashed and its return is discarded; `fetch_pc <= {redirect_pc[31:2], 2'b00}`; no issue in R.
  - Pop in R: an instruction accepted (valid & ready) in R counts as delivered. All others are dropped.
  - Back-to-back redirects: the last one wins.
- Reset: `rst` overrides everything, including redirect.
  - `fetch_pc = RESET_PC`, count = 0, `inflight` = 0, squash = 0.
  - Outputs during reset: `instr_valid` 0, `imem_en` 0, `imem_addr` 0, `instr` 0, `instr_pc` 0.
  - Reset mid-stream discards all buffered and in-flight data.

## Timing
- Cycle 0 is the first cycle with `rst` low: `imem_en`=1, `imem_addr`=`RESET_PC>>2`. Cycle 1: `imem_rdata` = mem[RESET_PC>>2]. Cycle 2: `instr_valid`=1.
- Fetch-to-output latency is 2 cycles. Sustained throughput is 1 instruction per cycle with `instr_ready` held high.
- Redirect asserted in cycle R: the first issue to the target is in R+1, and the target instruction becomes valid in R+3. `instr_valid`=0 in R+1 and R+2.
- Stall (`instr_ready`=0): at most 2 instructions are buffered, then `imem_en` deasserts. Releasing ready resumes issue in the same cycle as the first pop, with no bubble.

## Structure
- Shared package `cpu_pkg`: `INSTR_W`=32, `PC_W`=32, `PC_STEP`=4, `RESET_PC_DEFAULT`, plus a typedef for the {instr, pc} fetch bundle that the decoder stage also uses.
- Sub-module `fetch_skid_fifo`: 2-entry FIFO with push, pop, flush, and count. Top level holds the PC, the issue/squash logic, and the instance.

## Test plan
- Reset, then hold ready high; mem[i] = 32'h1000_0000 + i -> `instr` sequence 32'h1000_0000, 32'h1000_0001, ... on consecutive cycles starting at cycle 2, with `instr_pc` 0, 4, 8.
- Ready low from cycle 3 for 5 cycles -> exactly 2 entries buffered, `imem_en` low while full, head held stable, no instruction lost or duplicated after release.
- `redirect_pc` = 32'h0000_0103 in cycle 4 -> in-flight and buffered words discarded, `imem_addr` = 0x40 in cycle 5, `instr_pc` = 0x100 valid in cycle 7.
- Redirect on the same cycle as a pop, then a second redirect the next cycle -> popped instruction delivered, only the second target fetched.
- `fetch_pc` starting at 32'hFFFF_FFFC -> next PC 0, `imem_addr` wraps to 0.
- `rst` asserted mid-stream with 2 buffered -> `instr_valid` 0 next cycle, fetch restarts at `RESET_PC`.
